// File: rtl/rob_multi.sv
// Reorder buffer with two writeback ports, in-order single commit and flush on a mispredicted jump.
// Define ROB_PERF_EN to add the commit/flush performance counters.
module rob_multi #(
  parameter int ROB_WIDTH = 4,
  parameter int XLEN      = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  output logic [ROB_WIDTH-1:0] alloc_tag,
  input  logic [2:0]           alloc_op,
  input  logic [4:0]           alloc_rd,
  input  logic [XLEN-1:0]      alloc_pred_pc,
  input  logic                 wb0_valid,
  input  logic [ROB_WIDTH-1:0] wb0_tag,
  input  logic [XLEN-1:0]      wb0_wdata,
  input  logic [XLEN-1:0]      wb0_next_pc,
  input  logic                 wb1_valid,
  input  logic [ROB_WIDTH-1:0] wb1_tag,
  input  logic [XLEN-1:0]      wb1_wdata,
  input  logic [XLEN-1:0]      wb1_next_pc,
  output logic                 commit_valid,
  output logic [ROB_WIDTH-1:0] commit_tag,
  output logic [2:0]           commit_op,
  output logic [4:0]           commit_rd,
  output logic [XLEN-1:0]      commit_wdata,
  output logic                 flush,
  output logic [XLEN-1:0]      flush_pc,
`ifdef ROB_PERF_EN
  output logic [31:0]          perf_commit_cnt,
  output logic [31:0]          perf_flush_cnt,
`endif
  output logic [ROB_WIDTH:0]   count
);

  localparam int ROB_SIZE = 2**ROB_WIDTH;
  localparam logic [ROB_WIDTH-1:0] TAG_ONE  = ROB_WIDTH'(1);
  localparam logic [ROB_WIDTH:0]   CNT_ONE  = (ROB_WIDTH+1)'(1);
  localparam logic [ROB_WIDTH:0]   CNT_FULL = (ROB_WIDTH+1)'(ROB_SIZE);
  localparam logic [2:0] OP_JUMP = 3'd1;
  localparam logic [2:0] OP_BOTH = 3'd2;

  logic [ROB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_WIDTH:0]   count_q, count_d;
  logic                 valid_q [ROB_SIZE];
  logic                 valid_d [ROB_SIZE];
  logic                 ready_q [ROB_SIZE];
  logic                 ready_d [ROB_SIZE];
  logic [2:0]           op_q    [ROB_SIZE];
  logic [2:0]           op_d    [ROB_SIZE];
  logic [4:0]           rd_q    [ROB_SIZE];
  logic [4:0]           rd_d    [ROB_SIZE];
  logic [XLEN-1:0]      pred_q  [ROB_SIZE];
  logic [XLEN-1:0]      pred_d  [ROB_SIZE];
  logic [XLEN-1:0]      wdata_q [ROB_SIZE];
  logic [XLEN-1:0]      wdata_d [ROB_SIZE];
  logic [XLEN-1:0]      npc_q   [ROB_SIZE];
  logic [XLEN-1:0]      npc_d   [ROB_SIZE];

  logic                 commit_valid_q, commit_valid_d;
  logic [ROB_WIDTH-1:0] commit_tag_q, commit_tag_d;
  logic [2:0]           commit_op_q, commit_op_d;
  logic [4:0]           commit_rd_q, commit_rd_d;
  logic [XLEN-1:0]      commit_wdata_q, commit_wdata_d;
  logic                 flush_q, flush_d;
  logic [XLEN-1:0]      flush_pc_q, flush_pc_d;

  logic alloc_fire, commit_fire, mispredict;

  assign alloc_ready = rdy_in && !flush_q && (count_q != CNT_FULL);
  assign alloc_fire  = alloc_valid && alloc_ready;
  // Head readiness comes from registered state only, so a writeback never commits on its own edge.
  assign commit_fire = rdy_in && !flush_q && valid_q[head_q] && ready_q[head_q];
  assign mispredict  = commit_fire && ((op_q[head_q] == OP_JUMP) || (op_q[head_q] == OP_BOTH))
                       && (npc_q[head_q] != pred_q[head_q]);

  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    valid_d        = valid_q;
    ready_d        = ready_q;
    op_d           = op_q;
    rd_d           = rd_q;
    pred_d         = pred_q;
    wdata_d        = wdata_q;
    npc_d          = npc_q;
    commit_valid_d = commit_valid_q;
    commit_tag_d   = commit_tag_q;
    commit_op_d    = commit_op_q;
    commit_rd_d    = commit_rd_q;
    commit_wdata_d = commit_wdata_q;
    flush_d        = flush_q;
    flush_pc_d     = flush_pc_q;
    if (rdy_in) begin
      commit_valid_d = commit_fire;
      flush_d        = mispredict;
      // Port 1 is applied first so port 0 overrides it on a shared tag.
      if (!flush_q && wb1_valid && valid_q[wb1_tag]) begin
        ready_d[wb1_tag] = 1'b1;
        wdata_d[wb1_tag] = wb1_wdata;
        npc_d[wb1_tag]   = wb1_next_pc;
      end
      if (!flush_q && wb0_valid && valid_q[wb0_tag]) begin
        ready_d[wb0_tag] = 1'b1;
        wdata_d[wb0_tag] = wb0_wdata;
        npc_d[wb0_tag]   = wb0_next_pc;
      end
      if (alloc_fire) begin
        valid_d[tail_q] = 1'b1;
        ready_d[tail_q] = 1'b0;
        op_d[tail_q]    = alloc_op;
        rd_d[tail_q]    = alloc_rd;
        pred_d[tail_q]  = alloc_pred_pc;
        tail_d          = tail_q + TAG_ONE;
      end
      if (commit_fire) begin
        commit_tag_d    = head_q;
        commit_op_d     = op_q[head_q];
        commit_rd_d     = rd_q[head_q];
        commit_wdata_d  = wdata_q[head_q];
        valid_d[head_q] = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = head_q + TAG_ONE;
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (mispredict) begin
        flush_pc_d = npc_q[head_q];
        head_d     = '0;
        tail_d     = '0;
        count_d    = '0;
        for (int i = 0; i < ROB_SIZE; i++) begin
          valid_d[i] = 1'b0;
          ready_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        valid_q[i] <= 1'b0;
        ready_q[i] <= 1'b0;
      end
      commit_valid_q <= 1'b0;
      commit_tag_q   <= '0;
      commit_op_q    <= '0;
      commit_rd_q    <= '0;
      commit_wdata_q <= '0;
      flush_q        <= 1'b0;
      flush_pc_q     <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      valid_q        <= valid_d;
      ready_q        <= ready_d;
      commit_valid_q <= commit_valid_d;
      commit_tag_q   <= commit_tag_d;
      commit_op_q    <= commit_op_d;
      commit_rd_q    <= commit_rd_d;
      commit_wdata_q <= commit_wdata_d;
      flush_q        <= flush_d;
      flush_pc_q     <= flush_pc_d;
    end
  end

  // Payload is only meaningful behind a valid bit, so it needs no reset.
  always_ff @(posedge clk_in) begin
    op_q    <= op_d;
    rd_q    <= rd_d;
    pred_q  <= pred_d;
    wdata_q <= wdata_d;
    npc_q   <= npc_d;
  end

`ifdef ROB_PERF_EN
  logic [31:0] perf_commit_q, perf_commit_d, perf_flush_q, perf_flush_d;

  always_comb begin
    perf_commit_d = perf_commit_q;
    perf_flush_d  = perf_flush_q;
    if (commit_fire) perf_commit_d = perf_commit_q + 32'd1;
    if (mispredict)  perf_flush_d  = perf_flush_q + 32'd1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      perf_commit_q <= '0;
      perf_flush_q  <= '0;
    end else begin
      perf_commit_q <= perf_commit_d;
      perf_flush_q  <= perf_flush_d;
    end
  end

  assign perf_commit_cnt = perf_commit_q;
  assign perf_flush_cnt  = perf_flush_q;
`endif

  assign alloc_tag    = tail_q;
  assign count        = count_q;
  assign commit_valid = commit_valid_q;
  assign commit_tag   = commit_tag_q;
  assign commit_op    = commit_op_q;
  assign commit_rd    = commit_rd_q;
  assign commit_wdata = commit_wdata_q;
  assign flush        = flush_q;
  assign flush_pc     = flush_pc_q;

endmodule

// File: tb/tb_rob_multi.sv
// Directed bench for rob_multi (4-entry build): commit order, port priority, flush and stall behaviour.
module tb_rob_multi;
  localparam int RW = 2;
  localparam int XL = 32;
  localparam int SZ = 4;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in;
  logic          alloc_valid, alloc_ready;
  logic [RW-1:0] alloc_tag;
  logic [2:0]    alloc_op;
  logic [4:0]    alloc_rd;
  logic [XL-1:0] alloc_pred_pc;
  logic          wb0_valid, wb1_valid;
  logic [RW-1:0] wb0_tag, wb1_tag;
  logic [XL-1:0] wb0_wdata, wb0_next_pc, wb1_wdata, wb1_next_pc;
  logic          commit_valid, flush;
  logic [RW-1:0] commit_tag;
  logic [2:0]    commit_op;
  logic [4:0]    commit_rd;
  logic [XL-1:0] commit_wdata, flush_pc;
  logic [RW:0]   count;
`ifdef ROB_PERF_EN
  logic [31:0]   perf_commit_cnt, perf_flush_cnt;
`endif

  rob_multi #(.ROB_WIDTH(RW), .XLEN(XL)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alloc_op(alloc_op), .alloc_rd(alloc_rd), .alloc_pred_pc(alloc_pred_pc),
    .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb0_wdata(wb0_wdata), .wb0_next_pc(wb0_next_pc),
    .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_wdata(wb1_wdata), .wb1_next_pc(wb1_next_pc),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_op(commit_op),
    .commit_rd(commit_rd), .commit_wdata(commit_wdata),
    .flush(flush), .flush_pc(flush_pc),
`ifdef ROB_PERF_EN
    .perf_commit_cnt(perf_commit_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .count(count)
  );

  always #5 clk_in = ~clk_in;

  int            n_checks = 0;
  int            n_pass = 0;
  int            n_commits = 0;
  logic [RW-1:0] exp_q [$];
  logic [2:0]    m_op    [SZ];
  logic [4:0]    m_rd    [SZ];
  logic [XL-1:0] m_pred  [SZ];
  logic [XL-1:0] m_wdata [SZ];
  logic [XL-1:0] m_npc   [SZ];
  logic          m_flush [SZ];
  logic [RW-1:0] m_tail;
  logic [RW-1:0] mon_t;
  logic          rdy_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_alloc(input logic [2:0] op, input logic [4:0] rd, input logic [XL-1:0] pred);
    alloc_valid = 1'b1; alloc_op = op; alloc_rd = rd; alloc_pred_pc = pred;
    #1;
    chk("alloc_ready", 64'(alloc_ready), 64'd1);
    chk("alloc_tag", 64'(alloc_tag), 64'(m_tail));
    m_op[m_tail] = op; m_rd[m_tail] = rd; m_pred[m_tail] = pred;
    m_wdata[m_tail] = '0; m_npc[m_tail] = '0; m_flush[m_tail] = 1'b0;
    exp_q.push_back(m_tail);
    m_tail = m_tail + 2'd1;
    tick();
    alloc_valid = 1'b0;
  endtask

  // upd=0 drives a writeback the DUT must ignore, so the model is left alone.
  task automatic do_wb(input int port, input logic [RW-1:0] tag, input logic [XL-1:0] data,
                       input logic [XL-1:0] npc, input bit upd);
    if (port == 0) begin
      wb0_valid = 1'b1; wb0_tag = tag; wb0_wdata = data; wb0_next_pc = npc;
    end else begin
      wb1_valid = 1'b1; wb1_tag = tag; wb1_wdata = data; wb1_next_pc = npc;
    end
    if (upd) begin
      m_wdata[tag] = data;
      m_npc[tag]   = npc;
      m_flush[tag] = ((m_op[tag] == 3'd1) || (m_op[tag] == 3'd2)) && (npc != m_pred[tag]);
    end
    tick();
    wb0_valid = 1'b0;
    wb1_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
  endtask

  always @(posedge clk_in) rdy_seen <= rdy_in && !rst_in;

  // Commit monitor: each fresh commit pulse pops the oldest expected tag.
  always @(negedge clk_in) begin
    if (!rst_in && rdy_seen) begin
      if (commit_valid) begin
        n_commits++;
        chk("commit_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_t = exp_q.pop_front();
          chk("commit_tag", 64'(commit_tag), 64'(mon_t));
          chk("commit_op", 64'(commit_op), 64'(m_op[mon_t]));
          chk("commit_rd", 64'(commit_rd), 64'(m_rd[mon_t]));
          chk("commit_wdata", 64'(commit_wdata), 64'(m_wdata[mon_t]));
          chk("commit_flush", 64'(flush), 64'(m_flush[mon_t]));
          if (m_flush[mon_t]) begin
            chk("flush_pc", 64'(flush_pc), 64'(m_npc[mon_t]));
            exp_q.delete();
          end
        end
      end else begin
        chk("flush_alone", 64'(flush), 64'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sent, wn, cyc, base;
    bit got;
    logic [RW-1:0] pend [$];
    logic [RW-1:0] t;
    logic [RW:0]   hold_cnt;
    logic          hold_cv;
    logic [RW-1:0] hold_ctag, hold_atag;

    rst_in = 1'b1; rdy_in = 1'b1; alloc_valid = 1'b0; alloc_op = '0; alloc_rd = '0;
    alloc_pred_pc = '0; wb0_valid = 1'b0; wb0_tag = '0; wb0_wdata = '0; wb0_next_pc = '0;
    wb1_valid = 1'b0; wb1_tag = '0; wb1_wdata = '0; wb1_next_pc = '0; m_tail = '0;
    for (int i = 0; i < SZ; i++) m_flush[i] = 1'b0;
    repeat (2) tick();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_commit_valid", 64'(commit_valid), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_flush_pc", 64'(flush_pc), 64'd0);
    chk("rst_commit_wdata", 64'(commit_wdata), 64'd0);
    chk("rst_alloc_tag", 64'(alloc_tag), 64'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    tick();

    // Fill all four slots; a fifth request is refused.
    for (int i = 0; i < SZ; i++) do_alloc(3'd0, 5'(i + 1), '0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(alloc_ready), 64'd0);
    alloc_valid = 1'b1;
    tick();
    alloc_valid = 1'b0;
    chk("full_hold_count", 64'(count), 64'd4);
    chk("full_wrap_tag", 64'(alloc_tag), 64'd0);

    // Out-of-order writeback, in-order commit.
    do_wb(0, 2'd2, 32'h22, '0, 1'b1);
    do_wb(0, 2'd0, 32'h00, '0, 1'b1);
    do_wb(1, 2'd1, 32'h11, '0, 1'b1);
    do_wb(1, 2'd3, 32'h33, '0, 1'b1);
    drain(20);
    chk("empty_count", 64'(count), 64'd0);

    // Writeback to an invalid slot is ignored; unready head does not commit.
    do_alloc(3'd0, 5'd7, '0);
    do_wb(0, 2'd1, 32'hBAD, '0, 1'b0);
    repeat (3) tick();
    chk("unready_count", 64'(count), 64'd1);

    // Both ports same tag: port 0 wins.
    do_alloc(3'd0, 5'd8, '0);
    wb0_valid = 1'b1; wb0_tag = 2'd1; wb0_wdata = 32'hA; wb0_next_pc = '0;
    wb1_valid = 1'b1; wb1_tag = 2'd1; wb1_wdata = 32'hB; wb1_next_pc = '0;
    m_wdata[1] = 32'hA;
    tick();
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    do_wb(1, 2'd0, 32'h55, '0, 1'b1);
    drain(20);

    // Correctly predicted jump: commit without flush, younger entries kept.
    do_alloc(3'd1, 5'd0, 32'h100);
    do_alloc(3'd0, 5'd3, '0);
    do_alloc(3'd0, 5'd4, '0);
    do_wb(0, 2'd2, 32'h2, 32'h100, 1'b1);
    tick();
    chk("hit_commit_valid", 64'(commit_valid), 64'd1);
    chk("hit_flush", 64'(flush), 64'd0);
    chk("hit_count", 64'(count), 64'd2);
    do_wb(0, 2'd3, 32'h3, '0, 1'b1);
    do_wb(1, 2'd0, 32'h4, '0, 1'b1);
    drain(20);

    // Mispredicted jump with two younger entries; same-edge alloc/writeback discarded.
    do_alloc(3'd1, 5'd9, 32'h100);
    do_alloc(3'd0, 5'd10, '0);
    do_alloc(3'd0, 5'd11, '0);
    do_wb(0, 2'd1, 32'h77, 32'h200, 1'b1);
    alloc_valid = 1'b1; alloc_op = 3'd0; alloc_rd = 5'd12;
    wb0_valid = 1'b1; wb0_tag = 2'd2; wb0_wdata = 32'h99; wb0_next_pc = '0;
    tick();
    alloc_valid = 1'b0; wb0_valid = 1'b0;
    chk("miss_flush", 64'(flush), 64'd1);
    chk("miss_flush_pc", 64'(flush_pc), 64'h200);
    chk("miss_commit_valid", 64'(commit_valid), 64'd1);
    chk("miss_count", 64'(count), 64'd0);
    chk("miss_alloc_tag", 64'(alloc_tag), 64'd0);
    chk("miss_alloc_ready", 64'(alloc_ready), 64'd0);
    m_tail = '0;
    tick();
    chk("post_flush", 64'(flush), 64'd0);
    chk("post_count", 64'(count), 64'd0);
    chk("post_alloc_ready", 64'(alloc_ready), 64'd1);

    // Stream ten entries with a three-cycle rdy_in stall.
    sent = 0; wn = 0; cyc = 0; base = n_commits;
    while ((sent < 10 || pend.size() != 0 || exp_q.size() != 0) && cyc < 200) begin
      cyc++;
      if (cyc == 5) begin
        wb0_valid = 1'b0;
        hold_cnt = count; hold_cv = commit_valid; hold_ctag = commit_tag; hold_atag = alloc_tag;
        rdy_in = 1'b0;
        alloc_valid = 1'b1;
        repeat (3) begin
          tick();
          chk("stall_count", 64'(count), 64'(hold_cnt));
          chk("stall_commit_valid", 64'(commit_valid), 64'(hold_cv));
          chk("stall_commit_tag", 64'(commit_tag), 64'(hold_ctag));
          chk("stall_alloc_tag", 64'(alloc_tag), 64'(hold_atag));
          chk("stall_alloc_ready", 64'(alloc_ready), 64'd0);
        end
        alloc_valid = 1'b0;
        rdy_in = 1'b1;
      end
      wb0_valid = 1'b0;
      alloc_valid = 1'b0;
      if (pend.size() != 0) begin
        t = pend.pop_front();
        wn++;
        wb0_valid = 1'b1; wb0_tag = t; wb0_wdata = 32'h1000 + 32'(wn); wb0_next_pc = '0;
        m_wdata[t] = 32'h1000 + 32'(wn);
        m_npc[t] = '0;
        m_flush[t] = 1'b0;
      end
      got = 1'b0;
      t = m_tail;
      if (sent < 10) begin
        alloc_op = 3'd0; alloc_rd = 5'(sent + 1); alloc_pred_pc = '0;
        #1;
        if (alloc_ready) begin
          chk("stream_tag", 64'(alloc_tag), 64'(m_tail));
          m_op[m_tail] = 3'd0; m_rd[m_tail] = 5'(sent + 1); m_pred[m_tail] = '0;
          m_flush[m_tail] = 1'b0;
          exp_q.push_back(m_tail);
          m_tail = m_tail + 2'd1;
          alloc_valid = 1'b1;
          got = 1'b1;
          sent++;
        end
      end
      tick();
      if (got) pend.push_back(t);
    end
    wb0_valid = 1'b0;
    alloc_valid = 1'b0;
    tick();
    chk("stream_commits", 64'(n_commits - base), 64'd10);
    chk("stream_queue", 64'(exp_q.size()), 64'd0);
    chk("stream_count", 64'(count), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/rob_multi.md
ROB_MULTI -- requirements
Module: rob_multi

Interface
REQ-001 SHALL have parameter ROB_WIDTH, default 4, tag width; depth ROB_SIZE = 2**ROB_WIDTH entries.
REQ-002 SHALL have parameter XLEN, default 32, data/PC width.
REQ-003 SHALL have ports clk_in input 1 (clock) and rst_in input 1 (reset, asynchronous, active-high).
REQ-004 SHALL have rdy_in  input  1  global enable; low freezes all state.
REQ-005 SHALL have alloc_valid input 1, alloc_ready output 1, alloc_tag output ROB_WIDTH: decoder allocation handshake and tag of the slot granted.
REQ-006 SHALL have alloc_op input 3, alloc_rd input 5, alloc_pred_pc input XLEN: op class (0 WRITE, 1 JUMP, 2 BOTH, 3 LS, 4 NOTHING), destination, predicted next PC.
REQ-007 SHALL have two writeback ports k=0,1: wbk_valid input 1, wbk_tag input ROB_WIDTH, wbk_wdata input XLEN, wbk_next_pc input XLEN.
REQ-008 SHALL have commit_valid output 1, commit_tag output ROB_WIDTH, commit_op output 3, commit_rd output 5, commit_wdata output XLEN.
REQ-009 SHALL have flush output 1 and flush_pc output XLEN.
REQ-010 SHALL have count output ROB_WIDTH+1, current occupancy.

Function
REQ-011 alloc_ready SHALL be combinational: rdy_in && !flush && count != ROB_SIZE; alloc_tag SHALL equal tail.
REQ-012 Allocation fires on alloc_valid && alloc_ready at posedge; entry at tail gets valid=1, ready=0, op/rd/pred_pc stored; tail increments modulo ROB_SIZE.
REQ-013 Writeback on wbk_valid to a valid entry SHALL set ready=1 and store wdata, next_pc; writeback to an invalid entry SHALL be ignored.
REQ-014 Both ports same tag same cycle: port 0 SHALL win.
REQ-015 At most one commit per cycle: if head entry valid and ready at posedge, next cycle commit_valid=1 for exactly one cycle with that entry's tag/op/rd/wdata; entry invalidated, head increments.
REQ-016 Writeback and commit SHALL not bypass: entry made ready at edge N commits at edge N+1 at earliest.
REQ-017 Simultaneous alloc and commit SHALL leave count unchanged; otherwise count +1 on alloc, -1 on commit.
REQ-018 Mispredict: committing JUMP or BOTH whose next_pc != pred_pc SHALL in the same edge assert flush=1 (one cycle) and flush_pc=next_pc, alongside commit_valid.
REQ-019 On that flush edge head, tail, count SHALL become 0 and all valid bits clear; same-cycle allocations and writebacks SHALL be discarded.
REQ-020 While flush=1 no allocation, writeback or commit SHALL be accepted.
REQ-021 JUMP/BOTH with next_pc == pred_pc SHALL commit with no flush.
REQ-022 rdy_in low: all registers hold, including commit_valid and flush.
REQ-023 head/tail SHALL wrap from ROB_SIZE-1 to 0; full/empty distinguished by count only.

Reset
REQ-024 rst_in high SHALL immediately set head=0, tail=0, count=0, all valid/ready=0, commit_valid=0, flush=0, commit_tag/op/rd/wdata=0, flush_pc=0, irrespective of rdy_in.
REQ-025 Reset mid-operation SHALL drop all in-flight entries; first allocation after release receives tag 0.

Configuration
REQ-026 With macro ROB_PERF_EN defined, SHALL add outputs perf_commit_cnt and perf_flush_cnt (32 bits each, reset 0, +1 per commit_valid / flush pulse, wrap at 2**32).
REQ-027 Without ROB_PERF_EN those ports and counters SHALL not exist; other behaviour identical.

Verification
REQ-028 ROB_WIDTH=2: allocate 4 WRITE ops -> tags 0,1,2,3, count=4, alloc_ready=0; fifth alloc_valid not accepted.
REQ-029 Writeback tag 2 then 0 then 1 (wdata 0x22,0x00,0x11) -> commits in order tags 0,1,2 with wdata 0x00,0x11,0x22, one per cycle.
REQ-030 wb0 and wb1 both tag 1, wdata 0xA / 0xB same cycle -> commit of tag 1 shows 0xA.
REQ-031 JUMP pred_pc 0x100, next_pc 0x200, two younger entries allocated -> flush=1, flush_pc=0x200, count=0, next alloc_tag=0.
REQ-032 JUMP pred_pc 0x100, next_pc 0x100 -> commit_valid=1, flush stays 0, younger entries retained.
REQ-033 Fill/drain 10 entries through size-4 buffer with rdy_in toggled low for 3 cycles mid-stream -> tags wrap 3->0, no state change while rdy_in low, all 10 commit in order.
